spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Shares the single off-chip SPI memory between the CPU's instruction-fetch port and its data-memory port. It arbitrates between the two requesters and serialises each granted request as one SPI mode-0 transaction: command, 24-bit address, then data. It sits between the CPU core and the `uio` SPI pins, replacing the direct connection from the program-memory fetcher to the pins.

## Interface
Parameters:
- `CMD_READ`, default 8'h03: SPI read opcode.
- `CMD_WRITE`, default 8'h02: SPI write opcode.
- `DATA_BASE`, default 24'h010000: base of the data window; data address = `DATA_BASE | {16'h0, d_addr}`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: when 0, no new grant is issued; a transaction in flight completes.
- `if_req` in 1: fetch request; held high until `if_ack`.
- `if_addr` in 16: fetch address; SPI address = {8'h00, if_addr}.
- `if_ack` out 1: one-cycle pulse; `if_rdata` is valid in that cycle.
- `if_rdata` out 16: fetched instruction, first received byte in [15:8].
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 8: data address.
- `d_wdata` in 8: write data.
- `d_ack` out 1: one-cycle pulse.
- `d_rdata` out 8: read data, valid with `d_ack`, held until the next data read completes.
- `spi_cs` out 1: chip select, active-low.
- `spi_sclk` out 1: SPI clock.
- `spi_mosi` out 1: serial data out.
- `spi_mosi_oe` out 1: 1 while `spi_cs` = 0.
- `spi_miso` in 1: serial data in.
- `busy` out 1: 1 in every state except IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: `spi_cs` = 1. All other outputs 0, including `spi_sclk`, `spi_mosi`, `spi_mosi_oe`, `if_ack`, `d_ack`, `if_rdata`, `d_rdata` and `busy`. The last-grant register is set to "data".
- IDLE, with `ena` = 1 and at least one request high:
  - Pick the winner (see Configuration).
  - Latch the command, address, write data and bit count.
  - Go to SHIFT.
- Bit counts:
  - Fetch: 48 bits (8 cmd + 24 addr + 16 rx).
  - Data read: 40 bits (8 + 24 + 8 rx).
  - Data write: 40 bits (8 + 24 + 8 tx).
- SHIFT:
  - `spi_cs` = 0.
  - Each bit takes 2 clk cycles: phase 0 with `sclk` = 0 and MOSI updated; phase 1 with `sclk` = 1 and `spi_miso` sampled at the clk edge that ends phase 1.
  - Bits are sent MSB first.
  - During rx bits, MOSI = 0.
- DONE:
  - `spi_cs` = 1 and `sclk` = 0.
  - The granted port's ack is pulsed and its rdata is updated in the same cycle.
  - Next state is IDLE.
- Address and data inputs are sampled only at grant; changes during the transaction are ignored.
- A request deasserted before grant is dropped with no side effects. A request deasserted after grant still completes and is acked.
- Only one ack is ever high at a time.

## Timing
- Count cycles with cycle 0 = the IDLE cycle in which the request is sampled.
- `spi_cs` falls at cycle 1.
- Ack cycle:
  - Fetch: `if_ack` at cycle 97.
  - Data read or write: `d_ack` at cycle 81.
- Minimum CS-high gap between transactions is 2 cycles (DONE + IDLE). A request held across an ack is regranted at the earliest in the IDLE cycle that follows DONE.
- `spi_sclk` never toggles while `spi_cs` = 1. The rising-edge count per transaction equals the bit count exactly.
- `rst_n` low mid-transaction: on that clk edge `spi_cs` → 1, `sclk` → 0 and the state → IDLE. No ack is issued and rdata keeps its reset value.
- `ena` falling mid-transaction: no effect until DONE; afterwards the block stays in IDLE.

## Configuration
- `SPI_ARB_RR_EN` defined: round-robin arbitration. When both requests are high in IDLE, the port that did not win the last grant wins.
  - The reset value of last-grant is "data", so fetch wins the first tie.
  - The last-grant register updates on every grant.
- `SPI_ARB_RR_EN` undefined: fixed priority, data over fetch. The last-grant register is not implemented.
- Single requests are granted immediately in both modes.

## Test plan
- Fetch, `if_addr` = 16'h1234, MISO model returns 16'hA55A:
  - MOSI carries 8'h03, 24'h001234.
  - 48 sclk rises occur.
  - `if_ack` at cycle 97 with `if_rdata` = 16'hA55A.
- Data write, `d_addr` = 8'h7F, `d_wdata` = 8'hC3:
  - MOSI carries 8'h02, 24'h01007F, 8'hC3.
  - `d_ack` at cycle 81.
  - `if_ack` stays 0 throughout.
- Data read, `d_addr` = 8'h05, model returns 8'h3C: `d_ack` at cycle 81 with `d_rdata` = 8'h3C.
- `if_req` and `d_req` both held continuously:
  - RR build: grants alternate fetch, data, fetch.
  - Non-RR build: data is granted every time.
- `rst_n` low at cycle 30 of a fetch: on the next edge `spi_cs` = 1, no `if_ack`, `busy` = 0.
- `ena` = 0 with `if_req` = 1: no grant and `spi_cs` stays 1. Raise `ena`: the grant occurs in the next IDLE cycle.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI memory between the instruction-fetch port
// and the data-memory port. Each grant becomes one SPI mode-0 transaction:
// 8-bit command, 24-bit address, then 16 rx bits (fetch), 8 rx bits (data
// read) or 8 tx bits (data write). Each SPI bit takes two clk cycles.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 allows new grants; an in-flight transaction completes
//   if_req/if_addr      fetch request (held until if_ack), 16-bit address
//   if_ack/if_rdata     one-cycle ack with fetched 16-bit word
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_rdata       one-cycle ack; d_rdata holds the last read byte
//   spi_cs/spi_sclk/spi_mosi/spi_mosi_oe/spi_miso  SPI pins
//   busy                high whenever the controller is not idle
//
// Configuration macro: SPI_ARB_RR_EN selects round-robin arbitration between
// simultaneous requests; when undefined, data has fixed priority over fetch.
module spi_mem_arbiter #(
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter logic [23:0] DATA_BASE = 24'h010000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_mosi_oe,
  input  logic        spi_miso,
  output logic        busy
);

  localparam int unsigned SR_W  = 48;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_FETCH = CNT_W'(47);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(39);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             phase;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_last;
  logic [SR_W-1:0]  tx_sr;
  logic [15:0]      rx_sr;
  logic             is_fetch;
  logic             is_write;

  logic             grant_fetch_c;
  logic             start_c;
  logic [SR_W-1:0]  load_c;
  logic [15:0]      rx_next_c;

  // Winner selection; only meaningful while start_c is high.
`ifdef SPI_ARB_RR_EN
  logic last_data;
  assign grant_fetch_c = if_req & (~d_req | last_data);
`else
  assign grant_fetch_c = if_req & ~d_req;
`endif

  assign start_c   = ena & (if_req | d_req);
  assign rx_next_c = {rx_sr[14:0], spi_miso};

  // Left-aligned frame; trailing zeros keep MOSI low during rx bits.
  always_comb begin
    load_c = '0;
    if (grant_fetch_c) begin
      load_c = {CMD_READ, 8'h00, if_addr, 16'h0000};
    end else begin
      load_c = {(d_we ? CMD_WRITE : CMD_READ), DATA_BASE | {16'h0000, d_addr},
                (d_we ? d_wdata : 8'h00), 8'h00};
    end
  end

  // Arbitration, bit sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      bit_last    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      is_fetch    <= 1'b0;
      is_write    <= 1'b0;
      if_ack      <= 1'b0;
      if_rdata    <= '0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      spi_cs      <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      spi_mosi_oe <= 1'b0;
      busy        <= 1'b0;
`ifdef SPI_ARB_RR_EN
      last_data   <= 1'b1;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            spi_cs      <= 1'b0;
            spi_mosi_oe <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_mosi    <= load_c[SR_W-1];
            tx_sr       <= {load_c[SR_W-2:0], 1'b0};
            phase       <= 1'b0;
            bit_cnt     <= '0;
            bit_last    <= grant_fetch_c ? LAST_FETCH : LAST_DATA;
            is_fetch    <= grant_fetch_c;
            is_write    <= ~grant_fetch_c & d_we;
`ifdef SPI_ARB_RR_EN
            last_data   <= ~grant_fetch_c;
`endif
          end
        end
        SHIFT: begin
          if (!phase) begin
            spi_sclk <= 1'b1;
            phase    <= 1'b1;
          end else begin
            // End of the high phase: sample MISO, then advance or finish.
            spi_sclk <= 1'b0;
            phase    <= 1'b0;
            rx_sr    <= rx_next_c;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == bit_last) begin
              state       <= DONE;
              spi_cs      <= 1'b1;
              spi_mosi_oe <= 1'b0;
              spi_mosi    <= 1'b0;
              if (is_fetch) begin
                if_ack   <= 1'b1;
                if_rdata <= rx_next_c;
              end else begin
                d_ack <= 1'b1;
                if (!is_write) d_rdata <= rx_next_c[7:0];
              end
            end else begin
              spi_mosi <= tx_sr[SR_W-1];
              tx_sr    <= {tx_sr[SR_W-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Testbench for spi_mem_arbiter: SPI memory device model, byte-array
// reference model, and an ack scoreboard fed by the stimulus tasks.
module tb_spi_mem_arbiter;

  localparam logic [7:0]  CMD_RD = 8'h03;
  localparam logic [7:0]  CMD_WR = 8'h02;
  localparam logic [23:0] DBASE  = 24'h010000;
`ifdef SPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic        if_req, if_ack;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [7:0]  d_addr, d_wdata, d_rdata;
  logic        spi_cs, spi_sclk, spi_mosi, spi_mosi_oe, spi_miso, busy;

  spi_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_mosi_oe(spi_mosi_oe), .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [6:0]  nbits;
    logic        abort;
  } txn_t;

  int tests = 0;
  int fails = 0;

  txn_t        spi_exp[$];
  logic [15:0] if_exp[$];
  logic [7:0]  d_exp[$];

  logic [7:0] dev_mem [logic [23:0]];
  logic [7:0] ref_mem [logic [23:0]];
  bit         last_grant_data = 1'b1;
  logic [7:0] last_rd = 8'h00;
  int         sclk_bad = 0;
  int         mosi_rx_bad = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9};
  endfunction

  function automatic logic [7:0] dev_rd(input logic [23:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [23:0] a, input logic [7:0] v);
    dev_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // SPI memory device: mode 0, command/address then streaming bytes.
  bit          in_txn = 1'b0;
  int          nb;
  logic [31:0] hdr;
  logic [7:0]  wbyte, last_wbyte;
  always @(negedge clk) begin
    if (spi_cs && spi_sclk) sclk_bad++;
    if (!spi_cs) begin
      if (!in_txn) begin
        in_txn = 1'b1; nb = 0; hdr = '0; wbyte = '0; last_wbyte = '0;
      end
      if (spi_sclk) begin
        if (nb < 32) begin
          hdr = {hdr[30:0], spi_mosi};
        end else begin
          int j, i;
          logic [7:0] b;
          j = (nb - 32) / 8;
          i = 7 - ((nb - 32) % 8);
          if (hdr[31:24] == CMD_WR) begin
            wbyte = {wbyte[6:0], spi_mosi};
            if (i == 0) begin
              dev_mem[hdr[23:0] + 24'(j)] = wbyte;
              last_wbyte = wbyte;
            end
          end else begin
            if (spi_mosi) mosi_rx_bad++;
            b = dev_rd(hdr[23:0] + 24'(j));
            spi_miso = b[i];
          end
        end
        nb++;
      end
    end else if (in_txn) begin
      in_txn = 1'b0;
      spi_miso = 1'b0;
      if (spi_exp.size() == 0) begin
        check("spi_txn_unexp", 48'(spi_exp.size()), 48'd1);
      end else begin
        txn_t t;
        t = spi_exp.pop_front();
        if (!t.abort) begin
          check("spi_cmd", 48'(hdr[31:24]), 48'(t.cmd));
          check("spi_addr", 48'(hdr[23:0]), 48'(t.addr));
          check("sclk_rises", 48'(nb), 48'(t.nbits));
          if (t.cmd == CMD_WR) check("spi_wdata", 48'(last_wbyte), 48'(t.wdata));
        end
      end
    end
  end

  // Ack scoreboard.
  always @(negedge clk) begin
    if (if_ack || d_ack) check("one_ack", 48'(if_ack & d_ack), 48'd0);
    if (if_ack) begin
      if (if_exp.size() == 0) check("if_ack_unexp", 48'(if_exp.size()), 48'd1);
      else check("if_rdata", 48'(if_rdata), 48'(if_exp.pop_front()));
    end
    if (d_ack) begin
      if (d_exp.size() == 0) check("d_ack_unexp", 48'(d_exp.size()), 48'd1);
      else check("d_rdata", 48'(d_rdata), 48'(d_exp.pop_front()));
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 48'(busy), 48'd0);
  endtask

  // Reference prediction for one granted transaction.
  task automatic predict(input bit fetch, input bit we, input logic [23:0] sa, input logic [7:0] wd);
    txn_t t;
    t.cmd   = (fetch || !we) ? CMD_RD : CMD_WR;
    t.addr  = sa;
    t.wdata = (!fetch && we) ? wd : 8'h00;
    t.nbits = fetch ? 7'd48 : 7'd40;
    t.abort = 1'b0;
    spi_exp.push_back(t);
    if (fetch) begin
      if_exp.push_back({ref_rd(sa), ref_rd(sa + 24'd1)});
    end else begin
      if (we) ref_mem[sa] = wd;
      else last_rd = ref_rd(sa);
      d_exp.push_back(last_rd);
    end
    last_grant_data = !fetch;
  endtask

  task automatic do_txn(input bit fetch, input bit we, input logic [15:0] a, input logic [7:0] wd,
                        input int ena_wait, input bit ena_drop, input int rst_at);
    int n = 0;
    int bad = 0;
    bit acked = 1'b0;
    logic [23:0] sa;
    wait_idle();
    sa = fetch ? {8'h00, a} : (DBASE | {16'h0000, a[7:0]});
    if (rst_at > 0) begin
      txn_t t;
      t = '0;
      t.abort = 1'b1;
      spi_exp.push_back(t);
    end else begin
      predict(fetch, we, sa, wd);
    end
    if (ena_wait > 0) ena = 1'b0;
    if (fetch) begin if_req = 1'b1; if_addr = a; end
    else begin d_req = 1'b1; d_we = we; d_addr = a[7:0]; d_wdata = wd; end
    if (ena_wait > 0) begin
      for (int k = 0; k < ena_wait; k++) begin
        @(negedge clk);
        if (!spi_cs || busy) bad++;
      end
      check("ena_hold", 48'(bad), 48'd0);
      ena = 1'b1;
    end
    while (!acked && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) check("cs_fall", 48'(spi_cs), 48'd0);
      if (n == 2 && $urandom_range(0, 1) == 1) begin
        if_addr = 16'($urandom); d_addr = 8'($urandom); d_wdata = 8'($urandom); d_we = ~d_we;
      end
      if (n == 3 && $urandom_range(0, 3) == 0) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      if (ena_drop && n == 20) ena = 1'b0;
      if (rst_at > 0 && n == rst_at) begin
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("rst_abort", {spi_cs, busy, if_ack, if_rdata}, {1'b1, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        last_grant_data = 1'b1;
        last_rd = 8'h00;
        return;
      end
      if ((fetch && if_ack) || (!fetch && d_ack)) begin
        acked = 1'b1;
        check(fetch ? "if_ack_cycle" : "d_ack_cycle", 48'(n), fetch ? 48'd97 : 48'd81);
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    if (!acked) check("ack_timeout", 48'(acked), 48'd1);
    if (ena_drop) begin
      bad = 0;
      if_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (!spi_cs || busy) bad++;
      end
      check("ena_off_idle", 48'(bad), 48'd0);
      if_req = 1'b0;
      ena = 1'b1;
    end
  endtask

  // Both ports request continuously for three grants (reads only).
  task automatic contention(input logic [15:0] fa, input logic [7:0] da);
    int acks = 0;
    int n = 0;
    wait_idle();
    for (int g = 0; g < 3; g++) begin
      bit wf;
      wf = RR ? last_grant_data : 1'b0;
      predict(wf, 1'b0, wf ? {8'h00, fa} : (DBASE | {16'h0000, da}), 8'h00);
    end
    if_req = 1'b1; if_addr = fa;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    while (acks < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (if_ack || d_ack) begin
        acks++;
        if (acks == 3) begin
          if_req = 1'b0; d_req = 1'b0;
        end else begin
          @(negedge clk); n++;
          check("gap_idle", {spi_cs, busy}, 2'b10);
          @(negedge clk); n++;
          check("regrant", 48'(spi_cs), 48'd0);
        end
      end
    end
    if (acks < 3) check("contention_timeout", 48'(acks), 48'd3);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; spi_miso = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    preload(24'h001234, 8'hA5);
    preload(24'h001235, 8'h5A);
    preload(24'h010005, 8'h3C);
    repeat (3) @(negedge clk);
    check("reset_outs",
          {spi_cs, spi_sclk, spi_mosi, spi_mosi_oe, if_ack, d_ack, busy, if_rdata, d_rdata},
          {1'b1, 30'd0});
    rst_n = 1'b1;

    do_txn(1'b1, 1'b0, 16'h1234, 8'h00, 0, 1'b0, 0);
    do_txn(1'b0, 1'b1, 16'h007F, 8'hC3, 0, 1'b0, 0);
    do_txn(1'b0, 1'b0, 16'h0005, 8'h00, 0, 1'b0, 0);
    contention(16'h1234, 8'h05);
    do_txn(1'b1, 1'b0, 16'h4321, 8'h00, 0, 1'b0, 30);
    do_txn(1'b1, 1'b0, 16'h1234, 8'h00, 10, 1'b0, 0);
    do_txn(1'b0, 1'b0, 16'h007F, 8'h00, 0, 1'b1, 0);

    for (int r = 0; r < 20; r++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) do_txn(1'b1, 1'b0, 16'($urandom), 8'h00, 0, 1'b0, 0);
      else do_txn(1'b0, op == 1, 16'($urandom_range(0, 15)), 8'($urandom), 0, 1'b0, 0);
    end
    contention(16'($urandom), 8'($urandom_range(0, 15)));

    wait_idle();
    repeat (3) @(negedge clk);
    check("queues_empty", 48'(spi_exp.size() + if_exp.size() + d_exp.size()), 48'd0);
    check("sclk_while_cs_high", 48'(sclk_bad), 48'd0);
    check("mosi_during_rx", 48'(mosi_rx_bad), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
